tdoa_angle_estimator: RTL and testbench
=======================================

# tdoa_angle_estimator

Estimates sound-source bearing from the two microphone streams by timing the arrival difference of an acoustic onset between channels. It consumes the 18-bit sample streams and per-channel ready strobes produced by the two I2S receivers. It outputs an 8-bit angle (0–180°) plus a one-cycle valid strobe, replacing the free-running test angle that currently feeds the UART transmitter.

## Interface
- THRESH, 18'd20000: onset threshold on sample magnitude; a crossing means strictly greater.
- MAX_LAG, 8'd32: largest accepted inter-channel lag, in channel-0 sample ticks.
- DEG_PER_LAG, 8'd6: degrees of deflection from 90° per tick of lag.
- HOLDOFF, 16'd4800: sample ticks ignored after a valid measurement (about 0.1 s at 48 kHz).
- clock  in  1  system clock (100 MHz); one clock domain.
- reset  in  1  synchronous, active-high reset.
- data  in  [1:0][17:0]  two's-complement samples; [0] is mic 0, [1] is mic 1.
- data_rdy  in  [1:0]  one-cycle strobe per channel; `data[i]` is valid while `data_rdy[i]` is high.
- angle  out  8  latest bearing in degrees, 0..180, held between updates.
- angle_valid  out  1  one-cycle pulse when `angle` updates.
- busy  out  1  high in WAIT or HOLD.

## Operation
- Sample tick: a cycle where `data_rdy[0]` is high. All lag and holdoff counting uses ticks.
- Onset per channel: |data[i]| > THRESH, evaluated only on `data_rdy[i]` cycles.
  - |−131072| saturates to 131071.
- States:
  - IDLE: waiting for a first onset.
  - WAIT: one channel has fired; waiting for the other.
  - HOLD: holdoff after a valid measurement.
- IDLE:
  - Onset on one channel only: record that channel as first, clear `lag`, go to WAIT.
  - Onsets on both channels in the same cycle: lag = 0, output angle 90, go to HOLD.
- WAIT:
  - `lag` increments on each tick.
  - Further onsets on the first channel are ignored.
  - Onset on the other channel with lag ≤ MAX_LAG: compute the angle, pulse `angle_valid`, go to HOLD.
  - `lag` reaching MAX_LAG+1: timeout. Return to IDLE with no output; `angle` is unchanged.
  - An onset and the timeout increment in the same cycle: the onset wins, using the pre-increment `lag`.
- Angle computation (9-bit internal, saturating):
  - Mic 0 first: angle = max(0, 90 − lag·DEG_PER_LAG).
  - Mic 1 first: angle = min(180, 90 + lag·DEG_PER_LAG).
  - lag = 0: angle = 90.
- HOLD: `hold_cnt` counts ticks from 0. At HOLDOFF−1 return to IDLE. Onsets during HOLD are discarded.
- Reset values: `angle` = 8'd90, `angle_valid` = 0, `busy` = 0, state IDLE, all counters 0.
- Reset asserted mid-WAIT or mid-HOLD aborts with no output.

## Timing
- Onset detect stage is registered: the onset flag is valid 1 cycle after its `data_rdy` cycle.
- `angle` and `angle_valid` update exactly 2 cycles after the `data_rdy` cycle carrying the completing onset.
- `angle_valid` lasts exactly 1 cycle. `angle` holds until the next valid measurement or reset.
- `busy` follows the state register (same cycle as the state change).
- The two `data_rdy` strobes may be skewed by any number of cycles. Lag resolution is one sample tick.
- The consumer may sample `angle` at any time; no back-pressure.

## Structure
- Package `utils` holds:
  - `typedef logic signed [17:0] sample_t`
  - `typedef enum logic [1:0] {IDLE, WAIT, HOLD} tdoa_state_t`
  - `localparam ANGLE_CENTER = 8'd90`
  - `localparam ANGLE_MAX = 8'd180`
- Sub-module `onset_detector`, instantiated once per channel: abs plus threshold compare, registered `onset` output.
- Top level holds the FSM, lag/holdoff counters and angle arithmetic; target is about 200 lines in total.

## Test plan
- Reset, then no input: angle = 90, angle_valid = 0, busy = 0 indefinitely.
- Mic 0 sample 30000 at tick 0; mic 1 sample −25000 at tick 5 → angle = 60, one valid pulse 2 cycles after mic 1's `data_rdy`, busy high for the 4800-tick holdoff.
- Mic 1 first, mic 0 at lag 20 → 90 + 120 saturates → angle = 180. Mic 0 first at lag 15 → angle = 0.
- Both onsets in the same cycle → angle = 90. Mic 1 at −131072 is detected as magnitude 131071.
- Mic 0 onset, no mic 1 onset for 33 ticks → timeout, no pulse, angle unchanged, busy drops. A mic 1 onset at tick 40 then starts a new WAIT.
- Onsets during HOLD are ignored. Reset asserted during WAIT at lag 10 → next cycle: IDLE, angle = 90, no pulse.

Source files
------------

// File: rtl/tdoa_angle_estimator_pkg.sv
// Shared types and constants for the TDOA bearing estimator.
package utils;

  typedef logic signed [17:0] sample_t;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} tdoa_state_t;

  localparam logic [7:0] ANGLE_CENTER = 8'd90;
  localparam logic [7:0] ANGLE_MAX    = 8'd180;

endpackage

// File: rtl/tdoa_angle_estimator_onset_detector.sv
// Per-channel onset detector: saturating magnitude plus a strict threshold
// compare.
// The onset flag is registered, so it is visible one cycle after its strobe.
module onset_detector
  import utils::*;
#(
  parameter logic [17:0] THRESH = 18'd20000
) (
  input  logic    clock,
  input  logic    reset,
  input  sample_t sample,
  input  logic    sample_rdy,
  output logic    onset
);

  logic [17:0] mag;
  logic        onset_d;
  logic        onset_q;

  // Magnitude with -131072 clamped to 131071, then compare only on strobe cycles
  always_comb begin
    mag = '0;
    if (sample == {1'b1, {17{1'b0}}}) begin
      mag = {1'b0, {17{1'b1}}};
    end else if (sample[17]) begin
      mag = unsigned'(-sample);
    end else begin
      mag = unsigned'(sample);
    end
    onset_d = sample_rdy && (mag > THRESH);
  end

  // Register the onset flag
  always_ff @(posedge clock) begin
    if (reset) begin
      onset_q <= 1'b0;
    end else begin
      onset_q <= onset_d;
    end
  end

  assign onset = onset_q;

endmodule

// File: rtl/tdoa_angle_estimator.sv
// Bearing estimator: times the onset arrival difference between two mics in
// channel-0 sample ticks and converts the lag to a 0..180 degree angle.
module tdoa_angle_estimator
  import utils::*;
#(
  parameter logic [17:0] THRESH      = 18'd20000,
  parameter logic [7:0]  MAX_LAG     = 8'd32,
  parameter logic [7:0]  DEG_PER_LAG = 8'd6,
  parameter logic [15:0] HOLDOFF     = 16'd4800
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0][17:0] data,
  input  logic [1:0]       data_rdy,
  output logic [7:0]       angle,
  output logic             angle_valid,
  output logic             busy
);

  logic [1:0]  onset;
  logic        tick;
  logic        other_onset;

  tdoa_state_t state_q, state_d;
  logic        first_q, first_d;
  logic [7:0]  lag_q, lag_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]  angle_q, angle_d;
  logic        valid_q, valid_d;

  onset_detector #(.THRESH(THRESH)) u_onset0 (
    .clock      (clock),
    .reset      (reset),
    .sample     (sample_t'(data[0])),
    .sample_rdy (data_rdy[0]),
    .onset      (onset[0])
  );

  onset_detector #(.THRESH(THRESH)) u_onset1 (
    .clock      (clock),
    .reset      (reset),
    .sample     (sample_t'(data[1])),
    .sample_rdy (data_rdy[1]),
    .onset      (onset[1])
  );

  assign tick        = data_rdy[0];
  assign other_onset = first_q ? onset[0] : onset[1];

  // Deflection from centre, saturated at 0 (mic 0 first) or 180 (mic 1 first)
  function automatic logic [7:0] calc_angle(input logic mic1_first, input logic [7:0] lag);
    logic [15:0] deflect;
    logic [8:0]  result;
    deflect = {8'd0, lag} * {8'd0, DEG_PER_LAG};
    if (deflect >= {8'd0, ANGLE_CENTER}) begin
      result = mic1_first ? {1'b0, ANGLE_MAX} : 9'd0;
    end else if (mic1_first) begin
      result = {1'b0, ANGLE_CENTER} + {1'b0, deflect[7:0]};
    end else begin
      result = {1'b0, ANGLE_CENTER} - {1'b0, deflect[7:0]};
    end
    return result[7:0];
  endfunction

  // Next-state logic: onset pairing, lag timeout, holdoff countdown
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    lag_d      = lag_q;
    hold_cnt_d = hold_cnt_q;
    angle_d    = angle_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        lag_d      = '0;
        hold_cnt_d = '0;
        if (onset[0] && onset[1]) begin
          angle_d = ANGLE_CENTER;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (onset[0]) begin
          first_d = 1'b0;
          state_d = WAIT;
        end else if (onset[1]) begin
          first_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (other_onset && (lag_q <= MAX_LAG)) begin
          angle_d    = calc_angle(first_q, lag_q);
          valid_d    = 1'b1;
          hold_cnt_d = '0;
          lag_d      = '0;
          state_d    = HOLD;
        end else if (tick) begin
          if (lag_q >= MAX_LAG) begin
            lag_d   = '0;
            state_d = IDLE;
          end else begin
            lag_d = lag_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (hold_cnt_q == HOLDOFF - 16'd1) begin
            hold_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      lag_q      <= '0;
      hold_cnt_q <= '0;
      angle_q    <= ANGLE_CENTER;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      lag_q      <= lag_d;
      hold_cnt_q <= hold_cnt_d;
      angle_q    <= angle_d;
      valid_q    <= valid_d;
    end
  end

  assign angle       = angle_q;
  assign angle_valid = valid_q;
  assign busy        = (state_q == WAIT) || (state_q == HOLD);

endmodule

// File: tb/tb_tdoa_angle_estimator.sv
// Directed bench for tdoa_angle_estimator: one sample tick every two clocks,
// both channel strobes asserted together on each tick.
module tb_tdoa_angle_estimator;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0][17:0] data;
  logic [1:0]       data_rdy;
  logic [7:0]       angle;
  logic             angle_valid;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;
  int pulse_count = 0;
  int pulses_before;

  tdoa_angle_estimator dut (
    .clock       (clock),
    .reset       (reset),
    .data        (data),
    .data_rdy    (data_rdy),
    .angle       (angle),
    .angle_valid (angle_valid),
    .busy        (busy)
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  // Count every valid pulse so silent periods can be checked
  always @(posedge clock) begin
    if (angle_valid === 1'b1) pulse_count++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One sample tick on both channels; returns at the negedge two cycles later,
  // which is when a completing onset's angle becomes visible
  task automatic do_tick(input int s0, input int s1);
    data[0]  = 18'(s0);
    data[1]  = 18'(s1);
    data_rdy = 2'b11;
    @(negedge clock);
    data_rdy = 2'b00;
    data     = '0;
    @(negedge clock);
  endtask

  // Run through the holdoff, injecting an onset pair that must be ignored
  task automatic wait_hold(input string tag);
    int n;
    do_tick(0, 0);
    n = 1;
    check({tag, "_pulse_one_cycle"}, angle_valid, 1'b0);
    while (busy && n < 5000) begin
      if (n == 100) begin
        do_tick(30000, 30000);
        n++;
        check({tag, "_hold_onset_ignored"}, angle_valid, 1'b0);
      end else begin
        do_tick(0, 0);
        n++;
      end
    end
    check({tag, "_hold_released"}, busy, 1'b0);
    check({tag, "_hold_ticks"}, n, 4800);
  endtask

  initial begin
    reset    = 1'b1;
    data     = '0;
    data_rdy = 2'b00;
    repeat (3) @(negedge clock);
    check("reset_angle", angle, 8'd90);
    check("reset_valid", angle_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;

    repeat (5) do_tick(0, 0);
    check("idle_angle", angle, 8'd90);
    check("idle_busy", busy, 1'b0);

    // Exactly at threshold is not an onset
    do_tick(20000, 0);
    check("thresh_equal_ch0", busy, 1'b0);
    do_tick(0, 20000);
    check("thresh_equal_ch1", busy, 1'b0);

    // Mic 0 first, mic 1 at lag 5 -> 60
    do_tick(30000, 0);
    check("t60_wait_entered", busy, 1'b1);
    repeat (4) do_tick(0, 0);
    do_tick(0, -25000);
    check("t60_valid", angle_valid, 1'b1);
    check("t60_angle", angle, 8'd60);
    check("t60_busy", busy, 1'b1);
    wait_hold("t60");
    check("t60_angle_held", angle, 8'd60);

    // Mic 1 first, mic 0 at lag 20 -> saturates at 180
    do_tick(0, 30000);
    repeat (19) do_tick(0, 0);
    do_tick(-30000, 0);
    check("t180_valid", angle_valid, 1'b1);
    check("t180_angle", angle, 8'd180);
    wait_hold("t180");

    // Same-cycle onsets, mic 1 at full negative scale -> 90
    do_tick(30000, -131072);
    check("both_valid", angle_valid, 1'b1);
    check("both_angle", angle, 8'd90);
    check("both_busy", busy, 1'b1);
    wait_hold("both");

    // Mic 0 first, mic 1 at lag 15 -> exactly 0
    do_tick(30000, 0);
    repeat (14) do_tick(0, 0);
    do_tick(0, 30000);
    check("t0_valid", angle_valid, 1'b1);
    check("t0_angle", angle, 8'd0);
    wait_hold("t0");

    // Timeout: no partner within 32 ticks
    pulses_before = pulse_count;
    do_tick(30000, 0);
    repeat (32) do_tick(0, 0);
    check("timeout_lag32_busy", busy, 1'b1);
    do_tick(0, 0);
    check("timeout_busy", busy, 1'b0);
    check("timeout_angle", angle, 8'd0);
    check("timeout_no_pulse", pulse_count - pulses_before, 0);
    repeat (6) do_tick(0, 0);
    do_tick(0, 30000);
    check("retrigger_busy", busy, 1'b1);

    // Reset in the middle of WAIT at lag 10
    repeat (10) do_tick(0, 0);
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("midwait_reset_angle", angle, 8'd90);
    check("midwait_reset_valid", angle_valid, 1'b0);
    check("midwait_reset_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (3) do_tick(0, 0);
    check("post_reset_no_pulse", pulse_count - pulses_before, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
